otp_stream_decipher: RTL and testbench



---
 rtl/otp_pkg.sv | 21 ++
 rtl/otp_stream_decipher_if.sv | 21 ++
 rtl/otp_key_rotator.sv | 29 ++
 rtl/otp_stream_decipher.sv | 99 +++++++++
 tb/tb_otp_stream_decipher.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/otp_pkg.sv
// Shared constants and types for the one-time-pad serial encipherer/decipher pair.
// Bits travel LSB first; bit i of a byte pairs with key bit i.
package otp_pkg;

  localparam int OTP_KEY_W  = 8;
  localparam int OTP_BYTE_W = 8;
  localparam int OTP_BIT_IDX_W = $clog2(OTP_BYTE_W);
  localparam bit LSB_FIRST  = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Serial position idx carries this byte bit under the LSB-first order.
  function automatic logic serial_bit(input logic [OTP_BYTE_W-1:0] b,
                                      input logic [OTP_BIT_IDX_W-1:0] idx);
    return LSB_FIRST ? b[idx] : b[OTP_BIT_IDX_W'(OTP_BYTE_W - 1) - idx];
  endfunction

endpackage

// File: rtl/otp_stream_decipher_if.sv
// Ciphertext bit stream in, plaintext byte stream out, both valid/ready.
interface otp_stream_decipher_if #(parameter int BYTE_W = 8);

  logic              ct_valid;
  logic              ct_bit;
  logic              ct_ready;
  logic              pt_valid;
  logic [BYTE_W-1:0] pt_byte;
  logic              pt_ready;

  modport master (
    output ct_valid, ct_bit, pt_ready,
    input  ct_ready, pt_valid, pt_byte
  );

  modport slave (
    input  ct_valid, ct_bit, pt_ready,
    output ct_ready, pt_valid, pt_byte
  );

endinterface

// File: rtl/otp_key_rotator.sv
// Circular keystream register: load a pad, then rotate right one bit per advance.
module otp_key_rotator
  import otp_pkg::*;
#(
  parameter int KEY_W = OTP_KEY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [KEY_W-1:0] key,
  input  logic             advance,
  output logic             ks_bit
);

  logic [KEY_W-1:0] ks;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ks <= '0;
    end else if (load) begin
      ks <= key;
    end else if (advance) begin
      ks <= {ks[0], ks[KEY_W-1:1]};
    end
  end

  assign ks_bit = ks[0];

endmodule

// File: rtl/otp_stream_decipher.sv
// Deciphers an LSB-first ciphertext bit stream with a rotating pad and
// delivers whole plaintext bytes through a one-deep holding register.
//
// state | meaning
// IDLE  | no key loaded since reset; ciphertext is refused
// RUN   | keyed; bits are accepted and bytes assembled
module otp_stream_decipher
  import otp_pkg::*;
#(
  parameter int KEY_W  = OTP_KEY_W,
  parameter int BYTE_W = OTP_BYTE_W,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_load,
  input  logic [KEY_W-1:0]      key,
  otp_stream_decipher_if.slave  bus,
  output logic [CNT_W-1:0]      pt_count,
  output logic                  keyed
);

  localparam int BC_W = $clog2(BYTE_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(BYTE_W - 1);

  state_t            state;
  logic [BC_W-1:0]   bit_cnt;
  logic [BYTE_W-1:0] asm_q;
  logic [BYTE_W-1:0] asm_next;
  logic [BYTE_W-1:0] pt_byte_q;
  logic              pt_valid_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ks_bit;
  logic              d;
  logic              ct_ready_c;
  logic              accept;
  logic              complete;
  logic              deliver;

  // The last bit of a byte is held off only while the holding register is full.
  assign ct_ready_c = (state == RUN) && !key_load &&
                      !((bit_cnt == LAST_BIT) && pt_valid_q && !bus.pt_ready);
  assign accept     = bus.ct_valid && ct_ready_c;
  assign complete   = accept && (bit_cnt == LAST_BIT);
  assign deliver    = pt_valid_q && bus.pt_ready;
  assign d          = bus.ct_bit ^ ks_bit;

  always_comb begin
    asm_next          = asm_q;
    asm_next[bit_cnt] = d;
  end

  otp_key_rotator #(.KEY_W(KEY_W)) u_key_rotator (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (key_load),
    .key     (key),
    .advance (accept),
    .ks_bit  (ks_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      asm_q      <= '0;
      pt_byte_q  <= '0;
      pt_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (key_load) begin
        state   <= RUN;
        bit_cnt <= '0;
        asm_q   <= '0;
      end else if (accept) begin
        asm_q   <= asm_next;
        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
      end

      if (complete) begin
        pt_byte_q  <= asm_next;
        pt_valid_q <= 1'b1;
      end else if (deliver) begin
        pt_valid_q <= 1'b0;
      end

      if (deliver) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.ct_ready = ct_ready_c;
  assign bus.pt_valid = pt_valid_q;
  assign bus.pt_byte  = pt_byte_q;
  assign pt_count     = cnt_q;
  assign keyed        = (state == RUN);

endmodule

// File: tb/tb_otp_stream_decipher.sv
// Directed bench for otp_stream_decipher with hand-computed plaintext values.
module tb_otp_stream_decipher;

  logic        clk;
  logic        rst_n;
  logic        key_load;
  logic [7:0]  key;
  logic [15:0] pt_count;
  logic        keyed;
  int          checks;
  int          errors;

  otp_stream_decipher_if #(.BYTE_W(8)) bus ();

  otp_stream_decipher #(.KEY_W(8), .BYTE_W(8), .CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_load (key_load),
    .key      (key),
    .bus      (bus),
    .pt_count (pt_count),
    .keyed    (keyed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_key_load(input logic [7:0] k);
    key_load = 1'b1;
    key      = k;
    tick();
    key_load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_load = 1'b0; key = 8'h00;
    bus.ct_valid = 1'b0; bus.ct_bit = 1'b0; bus.pt_ready = 1'b1;
    #2;
    checks++; if (bus.ct_ready !== 1'b0) begin errors++; $display("FAIL reset_ct_ready got %b want 0", bus.ct_ready); end
    checks++; if (bus.pt_valid !== 1'b0) begin errors++; $display("FAIL reset_pt_valid got %b want 0", bus.pt_valid); end
    checks++; if (bus.pt_byte !== 8'h00) begin errors++; $display("FAIL reset_pt_byte got %h want 00", bus.pt_byte); end
    checks++; if (pt_count !== 16'd0) begin errors++; $display("FAIL reset_pt_count got %0d want 0", pt_count); end
    checks++; if (keyed !== 1'b0) begin errors++; $display("FAIL reset_keyed got %b want 0", keyed); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_idle_gating();
    bus.ct_valid = 1'b1; bus.ct_bit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.ct_ready !== 1'b0) begin errors++; $display("FAIL idle_ct_ready cyc %0d got %b want 0", i, bus.ct_ready); end
      tick();
      checks++; if (keyed !== 1'b0) begin errors++; $display("FAIL idle_keyed cyc %0d got %b want 0", i, keyed); end
      checks++; if (bus.pt_valid !== 1'b0) begin errors++; $display("FAIL idle_pt_valid cyc %0d got %b want 0", i, bus.pt_valid); end
    end
    bus.ct_valid = 1'b0;
  endtask

  task automatic test_basic_byte();
    logic [7:0] ct;
    ct = 8'h7F;
    bus.pt_ready = 1'b1;
    do_key_load(8'h2A);
    checks++; if (keyed !== 1'b1) begin errors++; $display("FAIL basic_keyed got %b want 1", keyed); end
    for (int i = 0; i < 8; i++) begin
      bus.ct_valid = 1'b1; bus.ct_bit = ct[i];
      #1;
      checks++; if (bus.ct_ready !== 1'b1) begin errors++; $display("FAIL basic_ct_ready bit %0d got %b want 1", i, bus.ct_ready); end
      tick();
      if (i < 7) begin
        checks++; if (bus.pt_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid bit %0d got %b want 0", i, bus.pt_valid); end
      end
    end
    bus.ct_valid = 1'b0;
    checks++; if (bus.pt_valid !== 1'b1) begin errors++; $display("FAIL basic_pt_valid got %b want 1", bus.pt_valid); end
    checks++; if (bus.pt_byte !== 8'h55) begin errors++; $display("FAIL basic_pt_byte got %h want 55", bus.pt_byte); end
    tick();
    checks++; if (bus.pt_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b want 0", bus.pt_valid); end
    checks++; if (pt_count !== 16'd1) begin errors++; $display("FAIL basic_pt_count got %0d want 1", pt_count); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] cts [3];
    logic [7:0] pts [3];
    logic [7:0] ct;
    cts = '{8'h7F, 8'h44, 8'h43};
    pts = '{8'h55, 8'h6E, 8'h69};
    bus.pt_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      ct = cts[b];
      for (int i = 0; i < 8; i++) begin
        bus.ct_valid = 1'b1; bus.ct_bit = ct[i];
        #1;
        checks++; if (bus.ct_ready !== 1'b1) begin errors++; $display("FAIL b2b_ct_ready byte %0d bit %0d got %b want 1", b, i, bus.ct_ready); end
        tick();
      end
      checks++; if (bus.pt_valid !== 1'b1) begin errors++; $display("FAIL b2b_pt_valid byte %0d got %b want 1", b, bus.pt_valid); end
      checks++; if (bus.pt_byte !== pts[b]) begin errors++; $display("FAIL b2b_pt_byte byte %0d got %h want %h", b, bus.pt_byte, pts[b]); end
    end
    bus.ct_valid = 1'b0;
    tick();
    checks++; if (pt_count !== 16'd4) begin errors++; $display("FAIL b2b_pt_count got %0d want 4", pt_count); end
  endtask

  task automatic test_backpressure();
    logic [7:0] ct;
    ct = 8'h7F;
    bus.pt_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.ct_valid = 1'b1; bus.ct_bit = ct[i];
      tick();
    end
    checks++; if (bus.pt_byte !== 8'h55) begin errors++; $display("FAIL bp_first_byte got %h want 55", bus.pt_byte); end
    ct = 8'h44;
    for (int i = 0; i < 7; i++) begin
      bus.ct_valid = 1'b1; bus.ct_bit = ct[i];
      #1;
      checks++; if (bus.ct_ready !== 1'b1) begin errors++; $display("FAIL bp_ct_ready bit %0d got %b want 1", i, bus.ct_ready); end
      tick();
    end
    bus.ct_bit = ct[7];
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.ct_ready !== 1'b0) begin errors++; $display("FAIL bp_stall cyc %0d got %b want 0", i, bus.ct_ready); end
      tick();
      checks++; if (bus.pt_byte !== 8'h55 || bus.pt_valid !== 1'b1) begin errors++; $display("FAIL bp_hold cyc %0d got %b/%h want 1/55", i, bus.pt_valid, bus.pt_byte); end
    end
    bus.pt_ready = 1'b1;
    #1;
    checks++; if (bus.ct_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b want 1", bus.ct_ready); end
    tick();
    bus.ct_valid = 1'b0;
    checks++; if (bus.pt_valid !== 1'b1 || bus.pt_byte !== 8'h6E) begin errors++; $display("FAIL bp_next_byte got %b/%h want 1/6e", bus.pt_valid, bus.pt_byte); end
    checks++; if (pt_count !== 16'd5) begin errors++; $display("FAIL bp_count_mid got %0d want 5", pt_count); end
    tick();
    checks++; if (pt_count !== 16'd6 || bus.pt_valid !== 1'b0) begin errors++; $display("FAIL bp_count_end got %0d/%b want 6/0", pt_count, bus.pt_valid); end
  endtask

  task automatic test_abort();
    logic [7:0] ct;
    bus.pt_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ct_valid = 1'b1; bus.ct_bit = i[0];
      tick();
    end
    key_load = 1'b1; key = 8'h2A;
    #1;
    checks++; if (bus.ct_ready !== 1'b0) begin errors++; $display("FAIL abort_ct_ready got %b want 0", bus.ct_ready); end
    tick();
    key_load = 1'b0;
    checks++; if (pt_count !== 16'd6 || bus.pt_valid !== 1'b0) begin errors++; $display("FAIL abort_untouched got %0d/%b want 6/0", pt_count, bus.pt_valid); end
    ct = 8'h7F;
    for (int i = 0; i < 8; i++) begin
      bus.ct_valid = 1'b1; bus.ct_bit = ct[i];
      tick();
    end
    bus.ct_valid = 1'b0;
    checks++; if (bus.pt_valid !== 1'b1 || bus.pt_byte !== 8'h55) begin errors++; $display("FAIL abort_byte got %b/%h want 1/55", bus.pt_valid, bus.pt_byte); end
    tick();
    checks++; if (pt_count !== 16'd7) begin errors++; $display("FAIL abort_count got %0d want 7", pt_count); end
  endtask

  task automatic test_other_key();
    logic [7:0] ct;
    do_key_load(8'hC3);
    ct = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      bus.ct_valid = 1'b1; bus.ct_bit = ct[i];
      tick();
    end
    bus.ct_valid = 1'b0;
    checks++; if (bus.pt_byte !== 8'h66) begin errors++; $display("FAIL key_c3_byte got %h want 66", bus.pt_byte); end
    tick();
  endtask

  task automatic test_async_reset();
    logic [7:0] ct;
    ct = 8'h7F;
    do_key_load(8'h2A);
    bus.pt_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.ct_valid = 1'b1; bus.ct_bit = ct[i];
      tick();
    end
    bus.ct_valid = 1'b0;
    checks++; if (bus.pt_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got %b want 1", bus.pt_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.pt_valid !== 1'b0 || bus.pt_byte !== 8'h00) begin errors++; $display("FAIL arst_pt got %b/%h want 0/00", bus.pt_valid, bus.pt_byte); end
    checks++; if (pt_count !== 16'd0 || keyed !== 1'b0) begin errors++; $display("FAIL arst_count_keyed got %0d/%b want 0/0", pt_count, keyed); end
    tick();
    rst_n = 1'b1;
    bus.ct_valid = 1'b1;
    bus.pt_ready = 1'b1;
    #1;
    checks++; if (bus.ct_ready !== 1'b0) begin errors++; $display("FAIL arst_needs_key got %b want 0", bus.ct_ready); end
    tick();
    bus.ct_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_idle_gating();
    test_basic_byte();
    test_back_to_back();
    test_backpressure();
    test_abort();
    test_other_key();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "bench timeout");
  end

endmodule
